// File: rtl/scan_capture_ctrl.sv
// Scan test sequencer for a WIDTH-bit mission/scan flop bank: shift in, capture d1, shift out.
// Optional built-in concurrent checks are compiled in with `define SCAN_CAPTURE_CTRL_ASSERT_EN.
module scan_capture_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] q,
    output logic             scan_en,
    output logic             capture_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] so_word
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] src;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge mclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (last)  state_nxt = CAPTURE;
            CAPTURE:            state_nxt = UNLOAD;
            UNLOAD:  if (last)  state_nxt = DONE;
            DONE:               state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scan_en    = (state == LOAD) || (state == UNLOAD);
        capture_en = (state == CAPTURE);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    // Pattern enters MSB first; the result leaves MSB first with zeros filling behind.
    always_ff @(posedge mclk) begin
        if (rst) begin
            q       <= '0;
            so_word <= '0;
            src     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    q <= d1;
                    if (start) begin
                        src <= pattern;
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    q   <= {q[WIDTH-2:0], src[WIDTH-1]};
                    src <= {src[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                CAPTURE: begin
                    q   <= d1;
                    cnt <= '0;
                end
                UNLOAD: begin
                    so_word <= {so_word[WIDTH-2:0], q[WIDTH-1]};
                    q       <= {q[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SCAN_CAPTURE_CTRL_ASSERT_EN
    logic [WIDTH-1:0] pat_q;

    // src is consumed while shifting, so keep an untouched copy for the capture check.
    always_ff @(posedge mclk) begin
        if (rst)                        pat_q <= '0;
        else if (state == IDLE && start) pat_q <= pattern;
        a_excl: assert property (disable iff (rst) !(scan_en && capture_en));
        a_cap:  assert property (disable iff (rst) (state == CAPTURE) |-> (q == pat_q));
    end

    a_done_pulse: assert property (@(posedge mclk) disable iff (rst) done |=> !done);
    a_busy_ign:   assert property (@(posedge mclk) disable iff (rst)
                                   (busy && start) |=> (state != LOAD || $past(state) == LOAD));
    a_latency:    assert property (@(posedge mclk) disable iff (rst)
                                   (state == IDLE && start) |-> ##(2*WIDTH+2) done);
`endif
endmodule

// File: tb/tb_scan_capture_ctrl.sv
// Scoreboard bench for scan_capture_ctrl: expected so_word values are queued at each start
// and popped when done pulses; per-cycle observations are recorded by a passive watcher.
module tb_scan_capture_ctrl;
    localparam int W = 8;
    localparam int RUN = 2 * W + 2;

    logic         mclk = 1'b0;
    logic         rst, start;
    logic [W-1:0] pattern, d1, q, so_word;
    logic         scan_en, capture_en, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    int           cap_cyc, done_cnt, scan_cyc, both_hi;
    logic [W-1:0] cap_q, q_done;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           done_at[$];

    scan_capture_ctrl #(.WIDTH(W)) dut (
        .mclk(mclk), .rst(rst), .start(start), .pattern(pattern), .d1(d1),
        .q(q), .scan_en(scan_en), .capture_en(capture_en), .busy(busy),
        .done(done), .so_word(so_word)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Records what the DUT shows each cycle; cycle 1 is the first cycle after the accept edge.
    task automatic watch(input int ncyc, input int sp1, input int sp2, input bit hold);
        cap_cyc = 0; done_cnt = 0; scan_cyc = 0; both_hi = 0;
        cap_q = 'x; q_done = 'x;
        got_q.delete(); done_at.delete();
        for (int c = 1; c <= ncyc; c++) begin
            if (capture_en) begin cap_q = q; cap_cyc = c; end
            if (scan_en) scan_cyc++;
            if (scan_en && capture_en) both_hi++;
            if (done) begin
                done_cnt++; done_at.push_back(c); got_q.push_back(so_word); q_done = q;
            end
            start = hold || (c == sp1) || (c == sp2);
            tick();
        end
    endtask

    task automatic accept(input logic [W-1:0] p, input logic [W-1:0] d);
        pattern = p; d1 = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pattern = 8'hFF; d1 = 8'h77;
        tick(); tick();
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", q); end
        n_cmp++; if (so_word !== 8'h00) begin n_err++; $display("FAIL reset_so got %h want 00", so_word); end
        n_cmp++; if ({scan_en, capture_en, busy, done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {scan_en, capture_en, busy, done}); end
        rst = 1'b0; start = 1'b0; d1 = 8'h5A;
        tick();
        n_cmp++; if (q !== 8'h5A) begin n_err++; $display("FAIL mission_q got %h want 5a", q); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_dropped busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [W-1:0] got;
        accept(8'hA5, 8'h3C);
        exp_q.push_back(8'h3C);
        watch(RUN, 0, 0, 1'b0);
        n_cmp++; if (cap_cyc !== W + 1) begin n_err++; $display("FAIL basic_cap_cycle got %0d want %0d", cap_cyc, W + 1); end
        n_cmp++; if (cap_q !== 8'hA5) begin n_err++; $display("FAIL basic_cap_q got %h want a5", cap_q); end
        n_cmp++; if (done_cnt !== 1 || done_at[0] !== RUN) begin
            n_err++; $display("FAIL basic_latency count=%0d at=%0d want 1 at %0d", done_cnt,
                              (done_cnt > 0) ? done_at[0] : -1, RUN); end
        n_cmp++; if (scan_cyc !== 2 * W || both_hi !== 0) begin
            n_err++; $display("FAIL basic_scan_en cycles=%0d overlap=%0d want %0d/0", scan_cyc, both_hi, 2 * W); end
        n_cmp++; if (q_done !== 8'h00) begin n_err++; $display("FAIL basic_q_done got %h want 00", q_done); end
        got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got !== exp_q.pop_front()) begin n_err++; $display("FAIL basic_so_word got %h want 3c", got); end
        n_cmp++; if (so_word !== 8'h3C || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_hold so=%h busy=%b want 3c/0", so_word, busy); end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] got;
        accept(8'h3C, 8'hC3);
        exp_q.push_back(8'hC3);
        watch(RUN + 20, 3, RUN, 1'b0);
        n_cmp++; if (done_cnt !== 1 || done_at[0] !== RUN) begin
            n_err++; $display("FAIL ignored_done count=%0d want 1 at %0d", done_cnt, RUN); end
        n_cmp++; if (scan_cyc !== 2 * W) begin n_err++; $display("FAIL ignored_scan got %0d want %0d", scan_cyc, 2 * W); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_busy got %b want 0", busy); end
        got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got !== exp_q.pop_front()) begin n_err++; $display("FAIL ignored_so_word got %h want c3", got); end
    endtask

    task automatic test_reset_mid_unload();
        logic [W-1:0] got;
        accept(8'h12, 8'h34);
        watch(W + 4, 0, 0, 1'b0);
        n_cmp++; if (scan_en !== 1'b1) begin n_err++; $display("FAIL mid_unload_pos scan_en=%b want 1", scan_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (so_word !== 8'h00 || busy !== 1'b0 || q !== 8'h00) begin
            n_err++; $display("FAIL mid_rst so=%h busy=%b q=%h want 00/0/00", so_word, busy, q); end
        watch(RUN + 4, 0, 0, 1'b0);
        n_cmp++; if (done_cnt !== 0 || scan_cyc !== 0) begin
            n_err++; $display("FAIL mid_rst_quiet done=%0d scan=%0d want 0/0", done_cnt, scan_cyc); end
        accept(8'hFF, 8'h81);
        exp_q.push_back(8'h81);
        watch(RUN, 0, 0, 1'b0);
        n_cmp++; if (cap_q !== 8'hFF) begin n_err++; $display("FAIL rerun_cap_q got %h want ff", cap_q); end
        got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (got !== exp_q.pop_front()) begin n_err++; $display("FAIL rerun_so_word got %h want 81", got); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, e;
        pattern = 8'h69; d1 = 8'h96; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h96);
        watch(3 * (RUN + 1), 0, 0, 1'b1);
        start = 1'b0;
        n_cmp++; if (done_cnt !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", done_cnt); end
        for (int i = 0; i < done_cnt && i < 3; i++) begin
            n_cmp++;
            if (done_at[i] !== RUN + i * (RUN + 1)) begin
                n_err++; $display("FAIL b2b_spacing run %0d at %0d want %0d", i, done_at[i], RUN + i * (RUN + 1));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (got !== e) begin n_err++; $display("FAIL b2b_so_word got %h want %h", got, e); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; d1 = '0;
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_mid_unload();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
